timesync_seq_ctrl: RTL and testbench
====================================

TIMESYNC_SEQ_CTRL -- requirements
Module: timesync_seq_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 1120, meaning OFDM burst length in samples ((64+16)*8+480); the fill target is 2*BURST_LEN.
REQ-002 Parameter TIMEOUT, default 200000, meaning the maximum cycles allowed per engine phase before the block enters ERROR.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  arms the sequencer from IDLE.
REQ-006 tx_done  input  1  synchronous restart of the sequence.
REQ-007 wren  input  1  input-sample strobe from the ADC-side writer.
REQ-008 eng_done  input  5  done pulses from the engines: [0] P, [1] R, [2] M, [3] detect, [4] CP-remove.
REQ-009 eng_start  output  5  one-cycle start pulses, same bit mapping as eng_done.
REQ-010 buf_req  input  4  sample-buffer port requests: [0] writer, [1] P, [2] R, [3] CP-remove.
REQ-011 buf_gnt  output  4  registered one-hot grant of the shared sample-buffer port.
REQ-012 phase  output  4  current state encoding.
REQ-013 in_full, out_ready, busy, err, ovf  output  1 each  status flags.

Function
REQ-014 States and encodings: IDLE=0, FILL=1, CALC_P=2, CALC_R=3, CALC_M=4, DETECT=5, CP_REM=6, STREAM=7, ERROR=8.
REQ-015 IDLE -> FILL when enable=1.
REQ-016 In FILL, each wren SHALL increment a 13-bit sample counter.
REQ-017 FILL -> CALC_P in the cycle the sample counter reaches 2*BURST_LEN; in_full SHALL be 1 from that cycle until restart.
REQ-018 On entry to CALC_P..CP_REM, the matching eng_start bit SHALL pulse for exactly one cycle, in the first cycle of that state.
REQ-019 Each engine state SHALL advance to the next state (CALC_P->CALC_R->CALC_M->DETECT->CP_REM->STREAM) one cycle after its matching eng_done bit is sampled high.
REQ-020 eng_done bits that do not match the current state SHALL be ignored.
REQ-021 A 20-bit watchdog SHALL clear on each state entry and count in every engine state.
REQ-022 When the watchdog reaches TIMEOUT, the block SHALL enter ERROR; err SHALL then stay 1 until rst or tx_done.
REQ-023 A matching eng_done and the timeout in the same cycle: the done SHALL win.
REQ-024 buf_gnt SHALL equal buf_req masked to the phase owner, registered with one cycle of latency.
REQ-025 Phase owners: FILL=writer, CALC_P=P, CALC_R=R, CP_REM=CP-remove; all other states grant nothing.
REQ-026 buf_gnt SHALL never have more than one bit set.
REQ-027 Grants SHALL drop in the first cycle of any new state.
REQ-028 wren outside FILL SHALL be dropped; wren in CALC_P..CP_REM SHALL set ovf, sticky until rst or tx_done.
REQ-029 out_ready=1 only in STREAM; busy=1 in FILL through CP_REM.
REQ-030 STREAM SHALL hold until tx_done.
REQ-031 tx_done (any state) SHALL take the block to IDLE on the next edge and clear the counter, watchdog, in_full, err and ovf.
REQ-032 tx_done SHALL override eng_done and wren in the same cycle.

Reset
REQ-033 rst=1 SHALL asynchronously force: state IDLE, counters 0, eng_start=0, buf_gnt=0, in_full=out_ready=busy=err=ovf=0.
REQ-034 rst mid-phase SHALL abort the phase with no start pulse or grant emitted.
REQ-035 Deassertion of rst SHALL be synchronous to clk (external synchronizer).

Structure
REQ-036 Shared package timesync_pkg SHALL hold: the state enum, FFT_POINT=64, CP_NUM=16, BURST_LEN=1120, requester indices, and engine bit indices.
REQ-037 Grant masking/registering SHALL live in sub-module ts_buff_arb; the FSM, counters and flags SHALL live in the top level.

Verification
REQ-038 Fill: enable, then 2240 wren pulses -> in_full=1 and phase=2 on the count-2240 edge; eng_start[0] pulses exactly once.
REQ-039 Full run: eng_done pulses 0..4 in order -> phase steps 2,3,4,5,6,7; out_ready=1 at phase 7; exactly 5 start pulses.
REQ-040 Timeout (TIMEOUT=100): no eng_done in CALC_R -> phase=8 and err=1 at watchdog 100; tx_done -> phase=0, err=0.
REQ-041 Arbitration: buf_req=4'b1111 held across all states -> buf_gnt = 0001, 0010, 0100, 0000, 0000, 1000 in FILL, CALC_P, CALC_R, CALC_M, DETECT, CP_REM respectively.
REQ-042 Stray inputs: eng_done[3] in CALC_P -> ignored; wren in CALC_M -> ovf=1, sample counter unchanged.
REQ-043 Mid-phase reset: rst asserted in CALC_P -> all outputs 0 immediately (before the next edge).

Source files
------------

// File: rtl/timesync_pkg.sv
// Shared definitions for the OFDM timing-sync sequencer.
//   - state_e      : sequencer state encoding (also driven out on phase)
//   - FFT_POINT, CP_NUM, BURST_LEN : burst geometry
//   - REQ_*        : bit indices into buf_req / buf_gnt
//   - ENG_*        : bit indices into eng_start / eng_done
//   - owner_mask() : which buffer requester owns the port in a state
//   - eng_mask()   : which engine belongs to a state
//   - next_state() : successor of each engine state on its done pulse
package timesync_pkg;

  localparam int FFT_POINT = 64;
  localparam int CP_NUM    = 16;
  localparam int BURST_LEN = (FFT_POINT + CP_NUM) * 8 + 480;  // 1120 samples

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FILL   = 4'd1,
    ST_CALC_P = 4'd2,
    ST_CALC_R = 4'd3,
    ST_CALC_M = 4'd4,
    ST_DETECT = 4'd5,
    ST_CP_REM = 4'd6,
    ST_STREAM = 4'd7,
    ST_ERROR  = 4'd8
  } state_e;

  localparam int REQ_WR = 0;
  localparam int REQ_P  = 1;
  localparam int REQ_R  = 2;
  localparam int REQ_CP = 3;

  localparam int ENG_P   = 0;
  localparam int ENG_R   = 1;
  localparam int ENG_M   = 2;
  localparam int ENG_DET = 3;
  localparam int ENG_CP  = 4;

  function automatic logic [3:0] owner_mask(input state_e s);
    logic [3:0] m;
    m = '0;
    case (s)
      ST_FILL:   m[REQ_WR] = 1'b1;
      ST_CALC_P: m[REQ_P]  = 1'b1;
      ST_CALC_R: m[REQ_R]  = 1'b1;
      ST_CP_REM: m[REQ_CP] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] eng_mask(input state_e s);
    logic [4:0] m;
    m = '0;
    case (s)
      ST_CALC_P: m[ENG_P]   = 1'b1;
      ST_CALC_R: m[ENG_R]   = 1'b1;
      ST_CALC_M: m[ENG_M]   = 1'b1;
      ST_DETECT: m[ENG_DET] = 1'b1;
      ST_CP_REM: m[ENG_CP]  = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic state_e next_state(input state_e s);
    state_e n;
    case (s)
      ST_CALC_P: n = ST_CALC_R;
      ST_CALC_R: n = ST_CALC_M;
      ST_CALC_M: n = ST_DETECT;
      ST_DETECT: n = ST_CP_REM;
      ST_CP_REM: n = ST_STREAM;
      default:   n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ts_buff_arb.sv
// Shared sample-buffer port arbiter.
// The current phase owns the port; the owner's request is passed through a
// register, so buf_gnt lags buf_req by one cycle. On a state change the
// grant register is cleared so that no grant survives into the first cycle
// of the new state, whoever owned the port before.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   state      : current sequencer state
//   state_chg  : sequencer leaves its state at the coming edge
//   buf_req    : [0] writer, [1] P, [2] R, [3] CP-remove
//   buf_gnt    : registered grant, at most one bit set
module ts_buff_arb
  import timesync_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  state_e     state,
  input  logic       state_chg,
  input  logic [3:0] buf_req,
  output logic [3:0] buf_gnt
);

  logic [3:0] gnt_q, gnt_d;

  // owner_mask() is one-hot or zero, so the grant can never be multi-hot.
  always_comb begin
    gnt_d = buf_req & owner_mask(state);
    if (state_chg) begin
      gnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  assign buf_gnt = gnt_q;

endmodule

// File: rtl/timesync_seq_ctrl.sv
// OFDM timing-sync sequencer.
// Fills the sample buffer with two bursts, then runs the P, R, M, detect
// and CP-remove engines one after another, then streams until tx_done.
// Each engine phase is guarded by a watchdog; expiry parks the block in
// ERROR until tx_done or rst.
// Handshake: eng_start[i] is a single-cycle pulse in the first cycle of the
// engine's state; eng_done[i] is a pulse, sampled only while that engine's
// state is current, and the state advances on the edge that samples it.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   enable              : leave IDLE
//   tx_done             : return to IDLE and clear all status (any state)
//   wren                : writer sample strobe (counted in FILL only)
//   eng_done/eng_start  : [0] P [1] R [2] M [3] detect [4] CP-remove
//   buf_req/buf_gnt     : sample-buffer port, see ts_buff_arb
//   phase               : current state encoding
//   in_full, out_ready, busy, err, ovf : status flags
module timesync_seq_ctrl #(
  parameter int BURST_LEN = 1120,
  parameter int TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_done,
  input  logic       wren,
  input  logic [4:0] eng_done,
  output logic [4:0] eng_start,
  input  logic [3:0] buf_req,
  output logic [3:0] buf_gnt,
  output logic [3:0] phase,
  output logic       in_full,
  output logic       out_ready,
  output logic       busy,
  output logic       err,
  output logic       ovf
);

  import timesync_pkg::*;

  localparam logic [12:0] FILL_TARGET = 13'(2 * BURST_LEN);
  localparam logic [19:0] WDOG_LAST   = 20'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [19:0] wdog_q, wdog_d;
  logic [4:0]  start_q, start_d;
  logic        in_full_q, in_full_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        eng_state;
  logic        done_hit;
  logic        state_chg;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    in_full_d = in_full_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    start_d   = '0;
    eng_state = (state_q >= ST_CALC_P) && (state_q <= ST_CP_REM);
    // Only the done bit of the engine owning the current state counts.
    done_hit  = |(eng_done & eng_mask(state_q));

    if (tx_done) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      wdog_d    = '0;
      in_full_d = 1'b0;
      err_d     = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end
        end
        ST_FILL: begin
          if (wren) begin
            cnt_d = cnt_q + 13'd1;
            if (cnt_d == FILL_TARGET) begin
              state_d   = ST_CALC_P;
              in_full_d = 1'b1;
            end
          end
        end
        ST_CALC_P, ST_CALC_R, ST_CALC_M, ST_DETECT, ST_CP_REM: begin
          wdog_d = wdog_q + 20'd1;
          // A done arriving in the expiry cycle still advances normally.
          if (done_hit) begin
            state_d = next_state(state_q);
          end else if (wdog_q == WDOG_LAST) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
          if (wren) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          // STREAM and ERROR hold until tx_done.
        end
      endcase
      if (state_d != state_q) begin
        wdog_d  = '0;
        start_d = eng_mask(state_d);
      end
    end
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wdog_q    <= '0;
      start_q   <= '0;
      in_full_q <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      start_q   <= start_d;
      in_full_q <= in_full_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  ts_buff_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .state     (state_q),
    .state_chg (state_chg),
    .buf_req   (buf_req),
    .buf_gnt   (buf_gnt)
  );

  assign eng_start = start_q;
  assign phase     = state_q;
  assign in_full   = in_full_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign out_ready = (state_q == ST_STREAM);
  assign busy      = (state_q >= ST_FILL) && (state_q <= ST_CP_REM);

endmodule

// File: tb/tb_timesync_seq_ctrl.sv
// Directed testbench for timesync_seq_ctrl (TIMEOUT shortened to 100).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_timesync_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tx_done = 1'b0;
  logic       wren = 1'b0;
  logic [4:0] eng_done = '0;
  logic [4:0] eng_start;
  logic [3:0] buf_req = '0;
  logic [3:0] buf_gnt;
  logic [3:0] phase;
  logic       in_full, out_ready, busy, err, ovf;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int base;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL time_limit: simulation did not finish, required finish before 2ms");
    $fatal(1, "time limit");
  end

  timesync_seq_ctrl #(.BURST_LEN(1120), .TIMEOUT(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tx_done   (tx_done),
    .wren      (wren),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .buf_req   (buf_req),
    .buf_gnt   (buf_gnt),
    .phase     (phase),
    .in_full   (in_full),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err),
    .ovf       (ovf)
  );

  // total start pulses observed (one sample per cycle)
  always @(negedge clk) begin
    if (!rst) start_cnt <= start_cnt + $countones(eng_start);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_n(input int n);
    wren = 1'b1;
    for (int i = 0; i < n; i++) step();
    wren = 1'b0;
  endtask

  task automatic pulse_done(input int b);
    eng_done = 5'd1 << b;
    step();
    eng_done = '0;
  endtask

  task automatic go_fill();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  // leaves the DUT in the first cycle of CALC_P
  task automatic enter_calc_p();
    go_fill();
    fill_n(2240);
  endtask

  task automatic restart();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    #1;
    vectors++; if (phase !== 4'd0) begin miscompares++; $display("FAIL reset_phase: got %0d want 0", phase); end
    vectors++; if ({eng_start, buf_gnt} !== 9'd0) begin miscompares++; $display("FAIL reset_start_gnt: got %b want 0", {eng_start, buf_gnt}); end
    vectors++; if ({in_full, out_ready, busy, err, ovf} !== 5'd0) begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {in_full, out_ready, busy, err, ovf}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    vectors++; if (phase !== 4'd0) begin miscompares++; $display("FAIL idle_hold: got %0d want 0", phase); end
  endtask

  task automatic test_fill();
    base = start_cnt;
    go_fill();
    vectors++; if (phase !== 4'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL fill_entry: got phase %0d busy %b want 1 1", phase, busy); end
    fill_n(2239);
    vectors++; if (phase !== 4'd1 || in_full !== 1'b0) begin miscompares++; $display("FAIL fill_2239: got phase %0d in_full %b want 1 0", phase, in_full); end
    fill_n(1);
    vectors++; if (phase !== 4'd2 || in_full !== 1'b1) begin miscompares++; $display("FAIL fill_2240: got phase %0d in_full %b want 2 1", phase, in_full); end
    vectors++; if (eng_start !== 5'b00001) begin miscompares++; $display("FAIL fill_start_p: got %b want 00001", eng_start); end
    step();
    vectors++; if (eng_start !== 5'b00000) begin miscompares++; $display("FAIL start_one_cycle: got %b want 00000", eng_start); end
    vectors++; if (start_cnt - base !== 1) begin miscompares++; $display("FAIL fill_start_count: got %0d want 1", start_cnt - base); end
    restart();
    vectors++; if (phase !== 4'd0 || in_full !== 1'b0) begin miscompares++; $display("FAIL fill_restart: got phase %0d in_full %b want 0 0", phase, in_full); end
  endtask

  task automatic test_full_run();
    logic [4:0] exp_start [5];
    exp_start[0] = 5'b00010; exp_start[1] = 5'b00100; exp_start[2] = 5'b01000;
    exp_start[3] = 5'b10000; exp_start[4] = 5'b00000;
    base = start_cnt;
    enter_calc_p();
    for (int b = 0; b < 5; b++) begin
      step();
      pulse_done(b);
      vectors++; if (phase !== 4'(b + 3)) begin miscompares++; $display("FAIL run_phase_%0d: got %0d want %0d", b, phase, b + 3); end
      vectors++; if (eng_start !== exp_start[b]) begin miscompares++; $display("FAIL run_start_%0d: got %b want %b", b, eng_start, exp_start[b]); end
    end
    vectors++; if (out_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL stream_flags: got out_ready %b busy %b want 1 0", out_ready, busy); end
    vectors++; if (start_cnt - base !== 5) begin miscompares++; $display("FAIL run_start_count: got %0d want 5", start_cnt - base); end
    eng_done = 5'b11111;
    repeat (4) step();
    eng_done = '0;
    vectors++; if (phase !== 4'd7) begin miscompares++; $display("FAIL stream_hold: got %0d want 7", phase); end
    restart();
    vectors++; if (phase !== 4'd0 || out_ready !== 1'b0 || in_full !== 1'b0) begin miscompares++; $display("FAIL stream_exit: got phase %0d out_ready %b in_full %b want 0 0 0", phase, out_ready, in_full); end
  endtask

  task automatic test_timeout();
    enter_calc_p();
    pulse_done(0);
    repeat (99) step();
    vectors++; if (phase !== 4'd3 || err !== 1'b0) begin miscompares++; $display("FAIL wdog_99: got phase %0d err %b want 3 0", phase, err); end
    step();
    vectors++; if (phase !== 4'd8 || err !== 1'b1) begin miscompares++; $display("FAIL wdog_100: got phase %0d err %b want 8 1", phase, err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL error_busy: got %b want 0", busy); end
    eng_done = 5'b11111;
    repeat (5) step();
    eng_done = '0;
    vectors++; if (phase !== 4'd8 || err !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got phase %0d err %b want 8 1", phase, err); end
    restart();
    vectors++; if (phase !== 4'd0 || err !== 1'b0) begin miscompares++; $display("FAIL error_clear: got phase %0d err %b want 0 0", phase, err); end
  endtask

  task automatic test_done_beats_timeout();
    enter_calc_p();
    pulse_done(0);
    repeat (99) step();
    pulse_done(1);
    vectors++; if (phase !== 4'd4 || err !== 1'b0) begin miscompares++; $display("FAIL done_vs_timeout: got phase %0d err %b want 4 0", phase, err); end
    restart();
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_gnt [6];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b0000; exp_gnt[4] = 4'b0000; exp_gnt[5] = 4'b1000;
    buf_req = 4'b1111;
    go_fill();
    vectors++; if (buf_gnt !== 4'b0000) begin miscompares++; $display("FAIL gnt_fill_entry: got %b want 0000", buf_gnt); end
    fill_n(1);
    vectors++; if (buf_gnt !== exp_gnt[0]) begin miscompares++; $display("FAIL gnt_fill: got %b want %b", buf_gnt, exp_gnt[0]); end
    fill_n(2239);
    for (int s = 1; s < 6; s++) begin
      vectors++; if (buf_gnt !== 4'b0000) begin miscompares++; $display("FAIL gnt_drop_%0d: got %b want 0000", s + 1, buf_gnt); end
      step();
      vectors++; if (buf_gnt !== exp_gnt[s]) begin miscompares++; $display("FAIL gnt_state_%0d: got %b want %b", s + 1, buf_gnt, exp_gnt[s]); end
      pulse_done(s - 1);
    end
    vectors++; if (phase !== 4'd7 || buf_gnt !== 4'b0000) begin miscompares++; $display("FAIL gnt_stream: got phase %0d gnt %b want 7 0000", phase, buf_gnt); end
    restart();
    buf_req = '0;
  endtask

  task automatic test_stray_inputs();
    enter_calc_p();
    pulse_done(3);
    pulse_done(1);
    vectors++; if (phase !== 4'd2 || ovf !== 1'b0) begin miscompares++; $display("FAIL stray_done: got phase %0d ovf %b want 2 0", phase, ovf); end
    pulse_done(0);
    pulse_done(1);
    vectors++; if (phase !== 4'd4) begin miscompares++; $display("FAIL stray_reach_m: got %0d want 4", phase); end
    fill_n(3);
    vectors++; if (ovf !== 1'b1 || phase !== 4'd4) begin miscompares++; $display("FAIL stray_ovf: got ovf %b phase %0d want 1 4", ovf, phase); end
    pulse_done(2);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    restart();
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_tx_override();
    enter_calc_p();
    eng_done = 5'b00001;
    tx_done = 1'b1;
    step();
    eng_done = '0;
    tx_done = 1'b0;
    vectors++; if (phase !== 4'd0 || eng_start !== 5'd0 || in_full !== 1'b0) begin miscompares++; $display("FAIL tx_over_done: got phase %0d start %b in_full %b want 0 0 0", phase, eng_start, in_full); end
    go_fill();
    fill_n(100);
    wren = 1'b1;
    tx_done = 1'b1;
    step();
    wren = 1'b0;
    tx_done = 1'b0;
    vectors++; if (phase !== 4'd0) begin miscompares++; $display("FAIL tx_over_wren: got %0d want 0", phase); end
    go_fill();
    fill_n(2239);
    vectors++; if (phase !== 4'd1) begin miscompares++; $display("FAIL refill_2239: got %0d want 1", phase); end
    fill_n(1);
    vectors++; if (phase !== 4'd2) begin miscompares++; $display("FAIL refill_2240: got %0d want 2", phase); end
    restart();
  endtask

  task automatic test_mid_reset();
    buf_req = 4'b1111;
    enter_calc_p();
    step();
    vectors++; if (buf_gnt !== 4'b0010 || in_full !== 1'b1) begin miscompares++; $display("FAIL pre_reset: got gnt %b in_full %b want 0010 1", buf_gnt, in_full); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (phase !== 4'd0 || {eng_start, buf_gnt} !== 9'd0) begin miscompares++; $display("FAIL mid_reset_phase: got phase %0d start/gnt %b want 0 0", phase, {eng_start, buf_gnt}); end
    vectors++; if ({in_full, out_ready, busy, err, ovf} !== 5'd0) begin miscompares++; $display("FAIL mid_reset_flags: got %b want 00000", {in_full, out_ready, busy, err, ovf}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++; if (phase !== 4'd0 || buf_gnt !== 4'b0000) begin miscompares++; $display("FAIL post_reset: got phase %0d gnt %b want 0 0000", phase, buf_gnt); end
    buf_req = '0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_run();
    test_timeout();
    test_done_beats_timeout();
    test_arbitration();
    test_stray_inputs();
    test_tx_override();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
